// File: rtl/xor_nn_pkg.sv
// Shared types and constants for the XOR_NN self-test sequencer.
// Decision threshold default is 0.5 in Q1.16.
package xor_nn_pkg;

   localparam int OUT_W = 17;
   localparam logic [3:0] EXPECTED = 4'b0110;
   localparam logic [OUT_W-1:0] THRESH_DEFAULT = 17'h08000;

   typedef enum logic {
      IDLE,
      WAIT
   } state_t;

   // Counter width able to hold latency-1, never narrower than one bit.
   function automatic int cnt_width(input int latency);
      return (latency > 1) ? $clog2(latency) : 1;
   endfunction

endpackage

// File: rtl/xor_nn_wait_timer.sv
// Loadable down-counter that paces the settle time of each stimulus pattern.
// The counter parks at zero, so zero is asserted whenever no wait is pending.
module xor_nn_wait_timer
   import xor_nn_pkg::*;
#(
   parameter int LATENCY = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic load,
   output logic zero
);

   localparam int CW = cnt_width(LATENCY);
   localparam logic [CW-1:0] LOAD_VAL = CW'(LATENCY - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/xor_nn_sequencer.sv
// Sweeps x through 0..3, samples nn_out LATENCY edges after each change,
// thresholds it and grades the decisions against the XOR truth table.
module xor_nn_sequencer
   import xor_nn_pkg::*;
#(
   parameter int               LATENCY = 4,
   parameter logic [OUT_W-1:0] THRESH  = THRESH_DEFAULT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [OUT_W-1:0] nn_out,
   output logic [1:0]       x,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [3:0]       result,
   output logic [3:0]       err_mask,
   output logic [OUT_W-1:0] min_hi,
   output logic [OUT_W-1:0] max_lo
);

   state_t     state;
   logic [1:0] idx;
   logic       timer_load;
   logic       timer_zero;
   logic       decision;
   logic [3:0] result_next;

   // Reload on sweep start and after every capture except the last.
   assign timer_load = ((state == IDLE) && start) ||
                       ((state == WAIT) && timer_zero && (idx != 2'd3));
   assign decision   = (nn_out >= THRESH);

   always_comb begin
      result_next      = result;
      result_next[idx] = decision;
   end

   xor_nn_wait_timer #(
      .LATENCY (LATENCY)
   ) u_timer (
      .clock (clock),
      .reset (reset),
      .load  (timer_load),
      .zero  (timer_zero)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         idx      <= 2'd0;
         x        <= 2'd0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         result   <= 4'd0;
         err_mask <= 4'd0;
         min_hi   <= '1;
         max_lo   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= WAIT;
                  idx      <= 2'd0;
                  x        <= 2'd0;
                  busy     <= 1'b1;
                  pass     <= 1'b0;
                  result   <= 4'd0;
                  err_mask <= 4'd0;
                  min_hi   <= '1;
                  max_lo   <= '0;
               end
            end
            WAIT: begin
               if (timer_zero) begin
                  result <= result_next;
                  // High cases track their weakest output, low cases their strongest.
                  if (EXPECTED[idx]) begin
                     if (nn_out < min_hi) begin
                        min_hi <= nn_out;
                     end
                  end else begin
                     if (nn_out > max_lo) begin
                        max_lo <= nn_out;
                     end
                  end
                  if (idx != 2'd3) begin
                     idx <= idx + 2'd1;
                     x   <= idx + 2'd1;
                  end else begin
                     state    <= IDLE;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     err_mask <= result_next ^ EXPECTED;
                     pass     <= ((result_next ^ EXPECTED) == 4'd0);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
